// File: rtl/dmem_byte_sequencer.sv
// Byte-serial data-memory sequencer for the RV32I load/store unit.
// Splits word/half/byte accesses into little-endian byte cycles on an 8-bit synchronous memory.
module dmem_byte_sequencer #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              sysclk,
  input  logic              sysreset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout
);

  typedef enum logic [1:0] {StIdle, StAccess, StCapture, StResp} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic              zext_q, zext_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        nbytes_q, nbytes_d;
  logic [2:0]        idx_q, idx_d;
  logic [31:0]       buf_q, buf_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [2:0]        req_nbytes;
  logic              req_legal;
  logic              req_misal;
  logic              req_bad;
  logic              last_byte;
  logic [31:0]       full_word;

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] i,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[{i, 3'b000} +: 8] = b;
    return r;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] n,
                                         input logic zext);
    logic [31:0] r;
    case (n)
      3'd1:    r = zext ? {24'h0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
      3'd2:    r = zext ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  // Request decode; a zero byte count marks an illegal funct3 size field.
  always_comb begin
    req_nbytes = 3'd0;
    case (req_funct3[1:0])
      2'b00:   req_nbytes = 3'd1;
      2'b01:   req_nbytes = 3'd2;
      2'b10:   req_nbytes = 3'd4;
      default: req_nbytes = 3'd0;
    endcase
    if (req_we) begin
      req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    end else begin
      req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                  (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    end
    req_misal = ((req_nbytes == 3'd2) && req_addr[0]) ||
                ((req_nbytes == 3'd4) && (req_addr[1:0] != 2'b00));
    req_bad   = !req_legal || req_misal;
  end

  assign last_byte = (idx_q == (nbytes_q - 3'd1));
  assign full_word = put_byte(buf_q, nbytes_q[1:0] - 2'd1, mem_dout);

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    zext_d   = zext_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    nbytes_d = nbytes_q;
    idx_d    = idx_q;
    buf_d    = buf_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    mem_addr = '0;
    mem_we   = 1'b0;
    mem_din  = 8'h00;
    done     = 1'b0;
    err      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d     = req_we;
          zext_d   = req_funct3[2];
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          nbytes_d = req_nbytes;
          idx_d    = 3'd0;
          buf_d    = 32'h0;
          rdata_d  = 32'h0;
          err_d    = req_bad;
          state_d  = req_bad ? StResp : StAccess;
        end
      end
      StAccess: begin
        mem_addr = addr_q + {{(ADDR_W-3){1'b0}}, idx_q};
        if (we_q) begin
          mem_we  = 1'b1;
          mem_din = wdata_q[{idx_q[1:0], 3'b000} +: 8];
        end else if (idx_q != 3'd0) begin
          // Synchronous memory: this cycle's mem_dout belongs to the previous address.
          buf_d = put_byte(buf_q, idx_q[1:0] - 2'd1, mem_dout);
        end
        idx_d = idx_q + 3'd1;
        if (last_byte) begin
          state_d = we_q ? StResp : StCapture;
        end
      end
      StCapture: begin
        buf_d   = full_word;
        rdata_d = extend(full_word, nbytes_q, zext_q);
        state_d = StResp;
      end
      StResp: begin
        done    = 1'b1;
        err     = err_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      zext_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      nbytes_q <= 3'd0;
      idx_q    <= 3'd0;
      buf_q    <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      zext_q   <= zext_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      nbytes_q <= nbytes_d;
      idx_q    <= idx_d;
      buf_q    <= buf_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign rdata = rdata_q;
  assign stall = req_valid & ~done;

endmodule
